// File: rtl/jk_ff_bank.sv
// jk_ff_bank: a bank of WIDTH flip-flops. At run time, mode selects JK, SR, D or T
// behaviour. The bank also tracks illegal SR inputs (a sticky flag and a per-bit mask)
// and counts updates that change q (a one-cycle pulse and a saturating counter).
module jk_ff_bank #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sr_err,
    output logic [WIDTH-1:0] err_mask,
    output logic             changed,
    output logic [CNT_W-1:0] chg_cnt
);

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_SR = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    mode_e            mode_sel;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] ill;
    logic [WIDTH-1:0] err_next;
    logic             chg;
    logic             cnt_full;

    assign mode_sel = mode_e'(mode);

    // Per-bit next state for the selected mode. Also flags the bits that see S=R=1.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        q_next = q;
        ill    = '0;
        if (en) begin
            unique case (mode_sel)
                MODE_JK: q_next = (a & ~q) | (~b & q);
                // Set on S only, clear on R only. S=R=0 and S=R=1 both hold.
                MODE_SR: begin
                    q_next = (a & ~b) | (q & ~(a ^ b));
                    ill    = a & b;
                end
                MODE_D:  q_next = a;
                MODE_T:  q_next = q ^ a;
                default: q_next = q;
            endcase
        end
    end

    // Error mask update. If a new illegal bit arrives in a clear cycle, it survives the clear.
    always_comb begin
        err_next = clr_err ? ill : (err_mask | ill);
    end

    assign chg      = en && (q_next != q);
    assign cnt_full = &chg_cnt;

    // Flip-flop bank state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples the values from before the edge.
        if (!rst_n) q <= RESET_VAL;
        else        q <= q_next;
    end

    // Sticky illegal-SR tracking. clr_err acts even when en=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mask <= '0;
            sr_err   <= 1'b0;
        end else begin
            err_mask <= err_next;
            sr_err   <= |err_next;
        end
    end

    // Change pulse and saturating change counter. Only reset clears the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed <= 1'b0;
            chg_cnt <= '0;
        end else begin
            changed <= chg;
            if (chg && !cnt_full) chg_cnt <= chg_cnt + 1'b1;
        end
    end

    assign qn = ~q;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed testbench for jk_ff_bank with WIDTH=4, RESET_VAL=0 and CNT_W=2.
// The expected values are worked out by hand in the comments next to each step.
module tb_jk_ff_bank;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             sr_err;
    logic [WIDTH-1:0] err_mask;
    logic             changed;
    logic [CNT_W-1:0] chg_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] JK = 2'b00, SR = 2'b01, D = 2'b10, T = 2'b11;

    jk_ff_bank #(.WIDTH(WIDTH), .RESET_VAL(4'b0000), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .clr_err  (clr_err),
        .q        (q),
        .qn       (qn),
        .sr_err   (sr_err),
        .err_mask (err_mask),
        .changed  (changed),
        .chg_cnt  (chg_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic [3:0] av,
                         input logic [3:0] bv, input logic c);
        en = e; mode = m; a = av; b = bv; clr_err = c;
    endtask

    // Step one clock edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, JK, 4'b0000, 4'b0000, 1'b0);
        #2;
        do_reset();

        // Test 1: load 1010, then pull rst_n low between edges.
        drive(1'b1, D, 4'b1010, 4'b0000, 1'b0);
        tick();
        check("t1_load_q", q, 4'b1010);
        check("t1_load_cnt", chg_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_q", q, 4'b0000);
        check("t1_async_qn", qn, 4'b1111);
        check("t1_async_err", {sr_err, err_mask}, 5'b0);
        check("t1_async_changed", changed, 0);
        check("t1_async_cnt", chg_cnt, 0);
        // An edge while reset is held must not load anything.
        drive(1'b1, D, 4'b1111, 4'b0000, 1'b0);
        tick();
        check("t1_held_q", q, 4'b0000);
        rst_n = 1'b1;

        // Test 2: load q=0011, then JK with a=0101, b=0110 -> 0101.
        drive(1'b1, D, 4'b0011, 4'b0000, 1'b0);
        tick();
        check("t2_setup_q", q, 4'b0011);
        drive(1'b1, JK, 4'b0101, 4'b0110, 1'b0);
        tick();
        check("t2_jk_q", q, 4'b0101);
        check("t2_jk_qn", qn, 4'b1010);
        check("t2_jk_changed", changed, 1);
        check("t2_jk_cnt", chg_cnt, 2);

        // Test 3: SR with a=1100, b=0110 -> 1101. Bit 2 is illegal and holds.
        drive(1'b1, SR, 4'b1100, 4'b0110, 1'b0);
        tick();
        check("t3_sr_q", q, 4'b1101);
        check("t3_sr_err", sr_err, 1);
        check("t3_sr_mask", err_mask, 4'b0100);
        check("t3_sr_cnt", chg_cnt, 3);

        // Test 4: a new error in a clear cycle is kept. A plain clear empties the mask.
        drive(1'b1, SR, 4'b0001, 4'b0001, 1'b1);
        tick();
        check("t4_clrnew_mask", err_mask, 4'b0001);
        check("t4_clrnew_err", sr_err, 1);
        check("t4_clrnew_q", q, 4'b1101);
        check("t4_clrnew_changed", changed, 0);
        drive(1'b1, D, 4'b1101, 4'b0000, 1'b1);
        tick();
        check("t4_clr_mask", err_mask, 4'b0000);
        check("t4_clr_err", sr_err, 0);

        // Test 5: T with a=1111 on q=0101 -> 1010. Then en=0 holds.
        drive(1'b1, D, 4'b0101, 4'b0000, 1'b0);
        tick();
        drive(1'b1, T, 4'b1111, 4'b0000, 1'b0);
        tick();
        check("t5_t_q", q, 4'b1010);
        check("t5_t_changed", changed, 1);
        check("t5_t_cnt_sat", chg_cnt, 3);
        drive(1'b0, T, 4'b1111, 4'b0000, 1'b0);
        tick();
        check("t5_hold_q", q, 4'b1010);
        check("t5_hold_changed", changed, 0);
        check("t5_hold_cnt", chg_cnt, 3);
        // With en=0, SR inputs raise no error, but clr_err still clears.
        drive(1'b1, SR, 4'b1000, 4'b1000, 1'b0);
        tick();
        check("t5_err_set_mask", err_mask, 4'b1000);
        check("t5_err_set_q", q, 4'b1010);
        drive(1'b0, SR, 4'b0100, 4'b0100, 1'b1);
        tick();
        check("t5_en0_clr_mask", err_mask, 4'b0000);
        check("t5_en0_clr_err", sr_err, 0);

        // Test 6: after reset, five toggles of bit 0 -> counter 1,2,3,3,3.
        do_reset();
        check("t6_reset_cnt", chg_cnt, 0);
        drive(1'b1, T, 4'b0001, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t6_toggle%0d_cnt", i), chg_cnt, (i < 3) ? i + 1 : 3);
            check($sformatf("t6_toggle%0d_q", i), q, (i % 2 == 0) ? 4'b0001 : 4'b0000);
            check($sformatf("t6_toggle%0d_changed", i), changed, 1);
        end
        drive(1'b1, D, 4'b0001, 4'b0000, 1'b0);
        tick();
        check("t6_nochg_changed", changed, 0);
        check("t6_nochg_cnt", chg_cnt, 3);
        check("t6_nochg_q", q, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
